// File: rtl/jk_call_latch.sv
// jk_call_latch: bank of JK-type floor-call latches with per-channel and
// global enables, selectable J=K=1 resolution, registered set/clear edge
// pulses and combinational summary outputs (count, any, lowest, highest).
// Optional build macro CALL_DEBOUNCE_EN: when defined, each call input is
// debounced into a one-shot that fires on the DEB_CYCLES-th consecutive
// high edge; when undefined, the call input is used as a level directly.
module jk_call_latch #(
    parameter int CHANNELS   = 8,
    parameter int IDX_W      = 3,
    parameter int JK11_MODE  = 0,
    parameter int DEB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] j,
    input  logic [CHANNELS-1:0] k,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] set_pulse,
    output logic [CHANNELS-1:0] clr_pulse,
    output logic [IDX_W:0]      pending_cnt,
    output logic                any_pending,
    output logic [IDX_W-1:0]    lowest_idx,
    output logic [IDX_W-1:0]    highest_idx
);

    // Out-of-range modes (3 and above) fall back to toggle.
    localparam logic [1:0] MODE_TOGGLE = 2'd0;
    localparam logic [1:0] MODE_SET    = 2'd1;
    localparam logic [1:0] MODE_CLEAR  = 2'd2;
    localparam logic [1:0] JK11_SEL    = (JK11_MODE == 1) ? MODE_SET :
                                         (JK11_MODE == 2) ? MODE_CLEAR : MODE_TOGGLE;

    // Reject parameter combinations the index/counter widths cannot hold.
    if (CHANNELS < 2 || CHANNELS > 32 || (1 << IDX_W) < CHANNELS ||
        DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_param
        $error("jk_call_latch: illegal parameter combination");
    end

    logic [CHANNELS-1:0] q_r;
    logic [CHANNELS-1:0] set_pulse_r;
    logic [CHANNELS-1:0] clr_pulse_r;
    logic [CHANNELS-1:0] q_next_s;
    logic [CHANNELS-1:0] je_s;

`ifdef CALL_DEBOUNCE_EN
    localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES);
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] deb_cnt_r [CHANNELS];

    // Per-channel run-length counter of consecutive high call samples; runs
    // regardless of the enables so a press landing on a disabled cycle is lost.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                deb_cnt_r[i] <= 8'd0;
            end else if (!j[i]) begin
                deb_cnt_r[i] <= 8'd0;
            end else if (deb_cnt_r[i] < DEB_MAX) begin
                deb_cnt_r[i] <= deb_cnt_r[i] + 8'd1;
            end else begin
                deb_cnt_r[i] <= deb_cnt_r[i];
            end
        end
    end

    // One-shot effective J: only the edge that completes the debounce window.
    always_comb begin
        je_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            je_s[i] = j[i] && (deb_cnt_r[i] == DEB_LAST);
        end
    end
`else
    // Without debounce the call input acts directly as a level.
    always_comb begin
        je_s = j;
    end
`endif

    // Next-state JK rule per channel, gated by global and channel enables.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable && ch_en[i]) begin
                case ({je_s[i], k[i]})
                    2'b00: q_next_s[i] = q_r[i];
                    2'b01: q_next_s[i] = 1'b0;
                    2'b10: q_next_s[i] = 1'b1;
                    2'b11: begin
                        case (JK11_SEL)
                            MODE_SET:   q_next_s[i] = 1'b1;
                            MODE_CLEAR: q_next_s[i] = 1'b0;
                            default:    q_next_s[i] = ~q_r[i];
                        endcase
                    end
                    default: q_next_s[i] = q_r[i];
                endcase
            end else begin
                q_next_s[i] = q_r[i];
            end
        end
    end

    // Latch state and edge pulses; reset clears everything without pulsing.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r         <= {CHANNELS{1'b0}};
            set_pulse_r <= {CHANNELS{1'b0}};
            clr_pulse_r <= {CHANNELS{1'b0}};
        end else begin
            q_r         <= q_next_s;
            set_pulse_r <= q_next_s & ~q_r;
            clr_pulse_r <= ~q_next_s & q_r;
        end
    end

    // Summary outputs derived from the current latch state (zero latency).
    always_comb begin
        pending_cnt = {(IDX_W+1){1'b0}};
        lowest_idx  = {IDX_W{1'b0}};
        highest_idx = {IDX_W{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            pending_cnt = pending_cnt + {{IDX_W{1'b0}}, q_r[i]};
            if (q_r[i]) begin
                highest_idx = IDX_W'(i);
            end else begin
                highest_idx = highest_idx;
            end
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (q_r[i]) begin
                lowest_idx = IDX_W'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
        end
        any_pending = |q_r;
    end

    assign q         = q_r;
    assign set_pulse = set_pulse_r;
    assign clr_pulse = clr_pulse_r;

endmodule

// File: tb/tb_jk_call_latch.sv
// Directed bench for jk_call_latch: three instances (J=K=1 modes 0/1/2)
// share the stimulus; expected values are hand-computed constants.
module tb_jk_call_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] ch_en;
    logic [7:0] j;
    logic [7:0] k;

    logic [7:0] q0, sp0, cp0, q1, sp1, cp1, q2, sp2, cp2;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       any0, any1, any2;
    logic [2:0] lo0, hi0, lo1, hi1, lo2, hi2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    jk_call_latch #(.CHANNELS(8), .IDX_W(3), .JK11_MODE(0), .DEB_CYCLES(4)) u_mode0 (
        .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .j(j), .k(k),
        .q(q0), .set_pulse(sp0), .clr_pulse(cp0), .pending_cnt(cnt0),
        .any_pending(any0), .lowest_idx(lo0), .highest_idx(hi0));

    jk_call_latch #(.CHANNELS(8), .IDX_W(3), .JK11_MODE(1), .DEB_CYCLES(4)) u_mode1 (
        .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .j(j), .k(k),
        .q(q1), .set_pulse(sp1), .clr_pulse(cp1), .pending_cnt(cnt1),
        .any_pending(any1), .lowest_idx(lo1), .highest_idx(hi1));

    jk_call_latch #(.CHANNELS(8), .IDX_W(3), .JK11_MODE(2), .DEB_CYCLES(4)) u_mode2 (
        .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .j(j), .k(k),
        .q(q2), .set_pulse(sp2), .clr_pulse(cp2), .pending_cnt(cnt2),
        .any_pending(any2), .lowest_idx(lo2), .highest_idx(hi2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode-0 instance: full state and summary comparison.
    task automatic check_all(input string tag, input logic [7:0] eq, input logic [7:0] es,
                             input logic [7:0] ec, input logic [3:0] en,
                             input logic [2:0] el, input logic [2:0] eh);
        check_val({tag, ".q"},   32'(q0),   32'(eq));
        check_val({tag, ".set"}, 32'(sp0),  32'(es));
        check_val({tag, ".clr"}, 32'(cp0),  32'(ec));
        check_val({tag, ".cnt"}, 32'(cnt0), 32'(en));
        check_val({tag, ".any"}, 32'(any0), 32'(eq != 8'h00));
        check_val({tag, ".lo"},  32'(lo0),  32'(el));
        check_val({tag, ".hi"},  32'(hi0),  32'(eh));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        ch_en  = 8'hFF;
        j      = 8'h5A;
        k      = 8'hA5;
        tick();
        tick();
        check_all("reset", 8'h00, 8'h00, 8'h00, 4'd0, 3'd0, 3'd0);
        check_val("reset.q1", 32'(q1), 32'h0);
        check_val("reset.q2", 32'(q2), 32'h0);
        j = 8'h00;
        k = 8'h00;
        reset = 1'b0;
        tick();
        check_all("idle", 8'h00, 8'h00, 8'h00, 4'd0, 3'd0, 3'd0);

`ifdef CALL_DEBOUNCE_EN
        // Short press (3 edges) never qualifies.
        j = 8'h08;
        for (int c = 0; c < 3; c++) tick();
        j = 8'h00;
        tick();
        check_val("deb.short", 32'(q0), 32'h00);
        // Held press: set on 4th edge, single pulse, then stable.
        j = 8'h08;
        for (int c = 0; c < 3; c++) tick();
        check_val("deb.pre", 32'(q0), 32'h00);
        tick();
        check_all("deb.set", 8'h08, 8'h08, 8'h00, 4'd1, 3'd3, 3'd3);
        for (int c = 0; c < 6; c++) tick();
        check_all("deb.hold", 8'h08, 8'h00, 8'h00, 4'd1, 3'd3, 3'd3);
        check_val("deb.hold.q1", 32'(q1), 32'h08);
        j = 8'h00;
        k = 8'hFF;
        tick();
        k = 8'h00;
        check_val("deb.clr", 32'(q0), 32'h00);
        // Reset mid-debounce discards the partial count.
        j = 8'h02;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check_val("deb.rst.noset", 32'(q0), 32'h00);
        tick();
        check_all("deb.rst.set", 8'h02, 8'h02, 8'h00, 4'd1, 3'd1, 3'd1);
        j = 8'h00;
`else
        // Set two channels.
        j = 8'h24;
        tick();
        j = 8'h00;
        check_all("set24", 8'h24, 8'h24, 8'h00, 4'd2, 3'd2, 3'd5);
        // Clear channel 2.
        k = 8'h04;
        tick();
        k = 8'h00;
        check_all("clr04", 8'h20, 8'h00, 8'h04, 4'd1, 3'd5, 3'd5);
        tick();
        check_all("quiet", 8'h20, 8'h00, 8'h00, 4'd1, 3'd5, 3'd5);
        // Clear all, then per-channel enable.
        k = 8'hFF;
        tick();
        k = 8'h00;
        check_all("clrall", 8'h00, 8'h00, 8'h20, 4'd0, 3'd0, 3'd0);
        ch_en = 8'hF0;
        j = 8'hFF;
        tick();
        j = 8'h00;
        check_all("chen", 8'hF0, 8'hF0, 8'h00, 4'd4, 3'd4, 3'd7);
        check_val("chen.q2", 32'(q2), 32'hF0);
        // Global enable low holds state.
        enable = 1'b0;
        ch_en = 8'hFF;
        k = 8'hFF;
        tick();
        check_all("endis", 8'hF0, 8'h00, 8'h00, 4'd4, 3'd4, 3'd7);
        enable = 1'b1;
        tick();
        k = 8'h00;
        check_all("enclr", 8'h00, 8'h00, 8'hF0, 4'd0, 3'd0, 3'd0);
        // Edge channels and full count.
        j = 8'h81;
        tick();
        check_all("ends", 8'h81, 8'h81, 8'h00, 4'd2, 3'd0, 3'd7);
        j = 8'hFF;
        tick();
        j = 8'h00;
        check_all("full", 8'hFF, 8'h7E, 8'h00, 4'd8, 3'd0, 3'd7);
        k = 8'h7F;
        tick();
        k = 8'h00;
        check_all("top", 8'h80, 8'h00, 8'h7F, 4'd1, 3'd7, 3'd7);
        k = 8'hFF;
        tick();
        // J=K=1 on channel 0 for four cycles.
        j = 8'h01;
        k = 8'h01;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("jk11.m0.q",   32'(q0),  (c % 2 == 0) ? 32'h1 : 32'h0);
            check_val("jk11.m0.set", 32'(sp0), (c % 2 == 0) ? 32'h1 : 32'h0);
            check_val("jk11.m0.clr", 32'(cp0), (c % 2 == 0) ? 32'h0 : 32'h1);
            check_val("jk11.m1.q",   32'(q1),  32'h1);
            check_val("jk11.m1.set", 32'(sp1), (c == 0) ? 32'h1 : 32'h0);
            check_val("jk11.m2.q",   32'(q2),  32'h0);
            check_val("jk11.m2.set", 32'(sp2), 32'h0);
        end
        j = 8'h00;
        k = 8'h00;
`endif
        // Reset from a non-zero state generates no pulses.
        j = 8'h11;
        tick();
        tick();
        j = 8'h00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("rst2", 8'h00, 8'h00, 8'h00, 4'd0, 3'd0, 3'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
